pipe_type_line: RTL and testbench
=================================

Name: pipe_type_line

Overview:
- Downstream consumer of the per-stage instruction-type decoders.
- Takes the five 2-character ASCII type codes (IF, ID, EX, MEM, WB; "xx" for a bubble), snapshots them on request, and formats them into one 16-character display line.
- Streams that line one character per valid/ready handshake to the character-display writer.
- Sits between the decoders and the display controller, in the debug/display path only.

Parameters:
- SEP, 8'h20, separator character written after each 2-char code.
- PAD, 8'h20, fill character at position 15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- type_if  input  16  ASCII code, IF stage; [15:8] first char, [7:0] second char
- type_id  input  16  ASCII code, ID stage
- type_ex  input  16  ASCII code, EX stage
- type_mem  input  16  ASCII code, MEM stage
- type_wb  input  16  ASCII code, WB stage
- snap  input  1  request to capture current codes and emit a line
- char_data  output  8  character being offered
- char_pos  output  4  column of char_data, 0..15
- char_valid  output  1  char_data/char_pos valid
- char_ready  input  1  display writer accepts the character when high with char_valid
- busy  output  1  high in LOAD and SEND
- line_done  output  1  one-cycle pulse after the last character is accepted

Behaviour:
- Reset (async, rst_n low): state IDLE; char_data 0, char_pos 0, char_valid 0, busy 0, line_done 0, pending 0; shadow and working registers set to "xx" per stage.
- Shadow capture: every rising edge with snap=1 loads all five inputs into the shadow registers, in any state.
- Pending: snap=1 while not in IDLE sets pending. Multiple such snaps coalesce into one pending request, which uses the latest shadow contents.
- Line layout, character index k:
  - 0..14: stage s = k/3 (0=IF .. 4=WB).
  - k%3==0 gives code[15:8]; k%3==1 gives code[7:0]; k%3==2 gives SEP.
  - k = 15 gives PAD.
- FSM:
  - IDLE: if snap or pending, go to LOAD.
  - LOAD: one cycle. Working registers <= shadow; pending cleared unless snap is also high this cycle; char_pos <= 0. Then SEND.
  - SEND: char_valid=1, char_data per layout from the working registers, char_pos = column.
    - On char_valid & char_ready: if char_pos == 15, go to DONE; otherwise char_pos+1.
    - Without ready: char_data and char_pos hold stable; the working registers never change in SEND.
  - DONE: line_done=1 for exactly this cycle; char_valid=0. If pending or snap, go to LOAD; else IDLE.
- Latency: snap sampled in IDLE at edge N → LOAD during cycle N+1 → first char_valid in cycle N+2. With char_ready held high, the line takes 16 cycles, and line_done is asserted in cycle N+18.
- char_valid is never withdrawn before acceptance. char_pos never exceeds 15 and does not wrap inside a frame.
- Reset mid-frame aborts immediately: no line_done, and pending is lost.
- Outputs are registered; no combinational path from char_ready to char_valid/char_data.

Test Plan:
- Reset then idle: rst_n low → all outputs 0; release with no snap for 20 cycles → char_valid stays 0, busy 0.
- Basic line: types IF="01", ID="08", EX="xx", MEM="11", WB="13", one snap pulse, char_ready=1 → 16 chars "01 08 xx 11 13 " + PAD at positions 0..15; first char_valid 2 cycles after snap; line_done 18 cycles after snap, exactly one cycle wide.
- Backpressure: same as the basic line but char_ready toggles 1-0-0-1 → each char held stable while ready=0, order and positions unchanged, no duplicates or drops.
- Snapshot isolation: snap, then change all inputs to "1f" during SEND without snap → emitted line still shows the original values.
- Coalesced pending: three snaps during SEND with inputs "02","03","04" (last value = "04" all stages) → exactly one extra frame after line_done; it shows "04" in every stage, and LOAD immediately follows DONE.
- Reset mid-frame: assert rst_n low at char_pos=7 → outputs 0 immediately, no line_done; a new snap after release produces a full frame from position 0.

Source files
------------

// File: rtl/pipe_type_line.sv
// Formats the five pipeline-stage type codes into a 16-character display line
// and streams it out one character per valid/ready handshake.
module pipe_type_line #(
  parameter logic [7:0] SEP = 8'h20,
  parameter logic [7:0] PAD = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] type_if,
  input  logic [15:0] type_id,
  input  logic [15:0] type_ex,
  input  logic [15:0] type_mem,
  input  logic [15:0] type_wb,
  input  logic        snap,
  output logic [7:0]  char_data,
  output logic [3:0]  char_pos,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        line_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [15:0] BUBBLE   = 16'h7878;  // "xx"
  localparam logic [3:0]  LAST_POS = 4'd15;

  state_t            state_q, state_d;
  logic [4:0][15:0]  shadow_q, shadow_d;
  logic [4:0][15:0]  work_q, work_d;
  logic              pending_q, pending_d;
  logic [7:0]        char_data_q, char_data_d;
  logic [3:0]        char_pos_q, char_pos_d;
  logic              char_valid_q, char_valid_d;
  logic              busy_q, busy_d;
  logic              line_done_q, line_done_d;
  logic              accept;

  // Column k: stage k/3 supplies chars 0,1 of its code, then SEP; column 15 is PAD.
  function automatic logic [7:0] line_char(input logic [4:0][15:0] codes,
                                           input logic [3:0]       k);
    logic [3:0] s;
    logic [3:0] r;
    logic [7:0] c;
    s = k / 4'd3;
    r = k % 4'd3;
    if (k == LAST_POS) begin
      c = PAD;
    end else begin
      case (r)
        4'd0:    c = codes[s[2:0]][15:8];
        4'd1:    c = codes[s[2:0]][7:0];
        default: c = SEP;
      endcase
    end
    return c;
  endfunction

  assign accept = (state_q == SEND) && char_valid_q && char_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= {5{BUBBLE}};
      work_q       <= {5{BUBBLE}};
      pending_q    <= 1'b0;
      char_data_q  <= '0;
      char_pos_q   <= '0;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      work_q       <= work_d;
      pending_q    <= pending_d;
      char_data_q  <= char_data_d;
      char_pos_q   <= char_pos_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      line_done_q  <= line_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (snap || pending_q) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: if (accept && (char_pos_q == LAST_POS)) state_d = DONE;
      DONE: state_d = (snap || pending_q) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: their next values derive from state_d so that
  // valid/busy/line_done line up with the state they describe.
  always_comb begin
    shadow_d    = shadow_q;
    work_d      = work_q;
    pending_d   = pending_q;
    char_data_d = char_data_q;
    char_pos_d  = char_pos_q;

    if (snap) shadow_d = {type_wb, type_mem, type_ex, type_id, type_if};

    if (state_q == LOAD) pending_d = 1'b0;
    if (snap && (state_q != IDLE)) pending_d = 1'b1;

    if (state_q == LOAD) begin
      work_d      = shadow_q;
      char_pos_d  = '0;
      char_data_d = line_char(shadow_q, 4'd0);
    end else if (accept && (char_pos_q != LAST_POS)) begin
      char_pos_d  = char_pos_q + 4'd1;
      char_data_d = line_char(work_q, char_pos_q + 4'd1);
    end

    char_valid_d = (state_d == SEND);
    busy_d       = (state_d == LOAD) || (state_d == SEND);
    line_done_d  = (state_d == DONE);
  end

  assign char_data  = char_data_q;
  assign char_pos   = char_pos_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;
  assign line_done  = line_done_q;

endmodule

// File: tb/tb_pipe_type_line.sv
// Scoreboard bench for pipe_type_line: expected characters are queued when a
// snapshot is requested and checked as the display writer accepts them.
module tb_pipe_type_line;

  localparam logic [7:0] SEP_C = 8'h20;
  localparam logic [7:0] PAD_C = 8'h2E;

  logic        clk;
  logic        rst_n;
  logic [15:0] type_if, type_id, type_ex, type_mem, type_wb;
  logic        snap;
  logic [7:0]  char_data;
  logic [3:0]  char_pos;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        line_done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_done = 0;
  int unsigned n_extra = 0;
  logic [11:0] sb_q[$];
  logic        bp_mode = 1'b0;

  pipe_type_line #(.SEP(SEP_C), .PAD(PAD_C)) dut (
    .clk(clk), .rst_n(rst_n),
    .type_if(type_if), .type_id(type_id), .type_ex(type_ex),
    .type_mem(type_mem), .type_wb(type_wb),
    .snap(snap),
    .char_data(char_data), .char_pos(char_pos), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .line_done(line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_types(input logic [15:0] a, b, c, d, e);
    type_if = a; type_id = b; type_ex = c; type_mem = d; type_wb = e;
  endtask

  task automatic push_frame(input logic [15:0] c0, c1, c2, c3, c4);
    logic [15:0] codes [5];
    logic [7:0]  line  [16];
    codes = '{c0, c1, c2, c3, c4};
    for (int s = 0; s < 5; s++) begin
      line[3*s]   = codes[s][15:8];
      line[3*s+1] = codes[s][7:0];
      line[3*s+2] = SEP_C;
    end
    line[15] = PAD_C;
    for (int k = 0; k < 16; k++) sb_q.push_back({4'(k), line[k]});
  endtask

  task automatic snap_pulse();
    @(negedge clk);
    snap = 1'b1;
    @(posedge clk);
    #1 snap = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (line_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"},  32'(char_data),  32'h0);
    chk({tag, "_pos"},   32'(char_pos),   32'h0);
    chk({tag, "_valid"}, 32'(char_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h0);
    chk({tag, "_done"},  32'(line_done),  32'h0);
  endtask

  // Backpressure pattern 1-0-0-1 on char_ready when enabled
  initial begin
    logic [3:0] pat;
    int unsigned idx;
    pat = 4'b1001;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        char_ready = pat[idx[1:0]];
        idx = (idx + 1) % 4;
      end
    end
  end

  // Acceptance monitor: pops the scoreboard and checks hold-while-stalled
  initial begin
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [3:0]  prev_pos;
    logic [11:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_pos   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(char_valid), 32'h1);
          chk("hold_data",  32'(char_data),  32'(prev_data));
          chk("hold_pos",   32'(char_pos),   32'(prev_pos));
        end
        if (char_valid && char_ready) begin
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("char_pos",  32'(char_pos),  32'(e[11:8]));
            chk("char_data", 32'(char_data), 32'(e[7:0]));
          end else begin
            n_extra++;
          end
        end
        prev_stall = char_valid && !char_ready;
        prev_data  = char_data;
        prev_pos   = char_pos;
        if (line_done) n_done++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int unsigned done0;
    bit seen;
    logic quiet;

    rst_n = 1'b0;
    snap = 1'b0;
    char_ready = 1'b1;
    set_types("01", "08", "xx", "11", "13");

    // Reset state and idle
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (char_valid || busy || line_done) quiet = 1'b0;
    end
    chk("idle_quiet", 32'(quiet), 32'h1);

    // Basic line with latency measurement
    done0 = n_done;
    push_frame("01", "08", "xx", "11", "13");
    snap_pulse();
    cyc = 1;
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_valid", 32'(char_valid), 32'h0);
    while (!char_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("first_valid_lat", cyc, 32'd2);
    while (!line_done && cyc < 60) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("line_done_lat", cyc, 32'd18);
    chk("done_valid_low", 32'(char_valid), 32'h0);
    @(posedge clk);
    #1 chk("line_done_width", 32'(line_done), 32'h0);
    chk("basic_sb_empty", 32'(sb_q.size()), 32'h0);
    @(negedge clk);
    chk("basic_done_count", n_done - done0, 32'd1);

    // Backpressure
    done0 = n_done;
    bp_mode = 1'b1;
    push_frame("01", "08", "xx", "11", "13");
    snap_pulse();
    wait_done(200, seen);
    chk("bp_done_seen", 32'(seen), 32'h1);
    bp_mode = 1'b0;
    char_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'h0);
    chk("bp_done_count", n_done - done0, 32'd1);

    // Snapshot isolation
    set_types("ab", "cd", "ef", "gh", "ij");
    push_frame("ab", "cd", "ef", "gh", "ij");
    snap_pulse();
    repeat (4) @(negedge clk);
    set_types("1f", "1f", "1f", "1f", "1f");
    wait_done(60, seen);
    chk("iso_done_seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
    chk("iso_sb_empty", 32'(sb_q.size()), 32'h0);

    // Coalesced pending
    done0 = n_done;
    set_types("05", "06", "07", "08", "09");
    push_frame("05", "06", "07", "08", "09");
    snap_pulse();
    repeat (3) @(negedge clk);
    set_types("02", "02", "02", "02", "02");
    snap_pulse();
    @(negedge clk);
    set_types("03", "03", "03", "03", "03");
    snap_pulse();
    @(negedge clk);
    set_types("04", "04", "04", "04", "04");
    snap_pulse();
    push_frame("04", "04", "04", "04", "04");
    set_types("77", "77", "77", "77", "77");
    wait_done(60, seen);
    chk("coal_done1_seen", 32'(seen), 32'h1);
    @(posedge clk);
    #1;
    chk("coal_load_busy", 32'(busy), 32'h1);
    chk("coal_load_valid", 32'(char_valid), 32'h0);
    @(posedge clk);
    #1 chk("coal_send_valid", 32'(char_valid), 32'h1);
    wait_done(60, seen);
    chk("coal_done2_seen", 32'(seen), 32'h1);
    repeat (20) @(negedge clk);
    chk("coal_done_count", n_done - done0, 32'd2);
    chk("coal_idle_busy", 32'(busy), 32'h0);
    chk("coal_sb_empty", 32'(sb_q.size()), 32'h0);

    // Reset mid-frame
    set_types("01", "08", "xx", "11", "13");
    push_frame("01", "08", "xx", "11", "13");
    snap_pulse();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (char_valid && char_pos == 4'd7) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_pos7_seen", 32'(seen), 32'h1);
    snap = 1'b1;
    rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    snap = 1'b0;
    sb_q.delete();
    done0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (char_valid || busy || line_done) quiet = 1'b0;
    end
    chk("mid_no_pending", 32'(quiet), 32'h1);
    chk("mid_no_done", n_done - done0, 32'd0);
    set_types("3a", "3b", "3c", "3d", "3e");
    push_frame("3a", "3b", "3c", "3d", "3e");
    snap_pulse();
    wait_done(60, seen);
    chk("mid_refr_done_seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
    chk("mid_sb_empty", 32'(sb_q.size()), 32'h0);
    chk("extra_chars", n_extra, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
